crc_code_stream_checker: RTL and testbench

//  Serial CRC-4 checker: the receive/decode end of the CRC-protected memory path.
//  - Accepts one codeword {data, crc} over a valid/ready handshake.
//  - Divides it bit-serially by the generator polynomial.
//  - Returns the data field, an error flag and a running error count over a second

---
 rtl/crc_code_stream_checker_if.sv | 27 ++
 rtl/crc_code_stream_checker.sv | 115 +++++++++++
 tb/tb_crc_code_stream_checker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/crc_code_stream_checker_if.sv
// Codeword-in / result-out handshake bundle for the serial CRC checker.
// master = producer/consumer side, slave = checker side.
interface crc_code_stream_checker_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 4
);
  localparam int CW = DATA_W + CRC_W;

  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_error;
  logic [CRC_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_error, out_syndrome
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_error, out_syndrome
  );
endinterface

// File: rtl/crc_code_stream_checker.sv
// Bit-serial CRC checker: divides one {data, crc} codeword MSB first by the
// generator, then reports data, syndrome, error flag and a saturating error count.
module crc_code_stream_checker #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 4,
  parameter logic [CRC_W-1:0] POLY   = 4'b0011,
  parameter int               CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  crc_code_stream_checker_if.slave   bus,
  output logic                       busy,
  input  logic                       clear_count,
  output logic [CNT_W-1:0]           err_count
);
  localparam int CW    = DATA_W + CRC_W;
  localparam int BIT_W = $clog2(CW);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CW - 1);

  logic [1:0]        state_reg, state_next;
  logic [CW-1:0]     shift_reg;
  logic [CRC_W-1:0]  rem_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              error_reg;
  logic [CRC_W-1:0]  synd_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              serial_bit;
  logic [CRC_W-1:0]  rem_step;
  logic [CW-1:0]     shift_rot;
  logic              accept;
  logic              deliver;
  logic              last_bit;

  assign serial_bit = shift_reg[CW-1];
  // Rotating rather than shifting leaves the original codeword in place after CW steps.
  assign shift_rot  = {shift_reg[CW-2:0], shift_reg[CW-1]};
  assign accept     = bus.in_valid && (state_reg == ST_IDLE);
  assign deliver    = (state_reg == ST_DONE) && bus.out_ready;
  assign last_bit   = (bit_cnt_reg == LAST_BIT);

  genvar gi;
  generate
    for (gi = 0; gi < CRC_W; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign rem_step[gi] = serial_bit ^ (rem_reg[CRC_W-1] & POLY[gi]);
      end else begin : g_upper
        assign rem_step[gi] = rem_reg[gi-1] ^ (rem_reg[CRC_W-1] & POLY[gi]);
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  if (deliver) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      rem_reg     <= '0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      error_reg   <= 1'b0;
      synd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        shift_reg   <= bus.in_code;
        rem_reg     <= '0;
        bit_cnt_reg <= '0;
      end else if (state_reg == ST_SHIFT) begin
        shift_reg   <= shift_rot;
        rem_reg     <= rem_step;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        if (last_bit) begin
          data_reg  <= shift_rot[CW-1:CRC_W];
          synd_reg  <= rem_step;
          error_reg <= |rem_step;
        end
      end
    end
  end

  // Clear takes priority over a coincident errored delivery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear_count) begin
      count_reg <= '0;
    end else if (deliver && error_reg && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.in_ready     = (state_reg == ST_IDLE);
  assign bus.out_valid    = (state_reg == ST_DONE);
  assign bus.out_data     = data_reg;
  assign bus.out_error    = error_reg;
  assign bus.out_syndrome = synd_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign err_count        = count_reg;
endmodule

// File: tb/tb_crc_code_stream_checker.sv
// Directed + randomized bench for crc_code_stream_checker; expectations come from
// polynomial long division and a saturating counter model kept here.
module tb_crc_code_stream_checker;
  localparam int               DATA_W = 8;
  localparam int               CRC_W  = 4;
  localparam logic [CRC_W-1:0] POLY   = 4'b0011;
  localparam int               CNT_W  = 8;
  localparam int               CW     = DATA_W + CRC_W;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             busy;
  logic             clear_count = 1'b0;
  logic [CNT_W-1:0] err_count;

  crc_code_stream_checker_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

  crc_code_stream_checker #(
    .DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .clear_count (clear_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int txn_cnt   = 0;
  int exp_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Remainder of code(x) divided by x^CRC_W + POLY, by plain long division.
  function automatic logic [CRC_W-1:0] ref_rem(input logic [CW-1:0] code);
    int unsigned v = code;
    int unsigned g = (1 << CRC_W) | POLY;
    for (int i = CW - 1; i >= CRC_W; i--)
      if (((v >> i) & 1) != 0) v = v ^ (g << (i - CRC_W));
    return CRC_W'(v);
  endfunction

  function automatic logic [CW-1:0] clean_code(input logic [DATA_W-1:0] d);
    logic [CW-1:0] shifted = {d, {CRC_W{1'b0}}};
    return shifted | CW'(ref_rem(shifted));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic [CW-1:0] code, input bit clr, input int hold);
    logic [CRC_W-1:0]  exp_syn = ref_rem(code);
    logic              exp_err = (exp_syn != 0);
    logic [DATA_W-1:0] exp_data = code[CW-1:CRC_W];
    int lat = 0;
    int waits = 0;
    while (!bus.in_ready && waits < 50) begin
      tick();
      waits++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    tick();
    bus.in_valid = 1'b0;
    bus.in_code  = CW'($urandom);
    while (!bus.out_valid && lat < 40) begin
      check("in_ready_while_busy", bus.in_ready, 0);
      tick();
      lat++;
    end
    check("latency", lat, CW);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = CW'($urandom);
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_data", bus.out_data, exp_data);
      check("hold_syndrome", bus.out_syndrome, exp_syn);
    end
    bus.in_valid = 1'b0;
    check("out_data", bus.out_data, exp_data);
    check("out_error", bus.out_error, exp_err);
    check("out_syndrome", bus.out_syndrome, exp_syn);
    check("busy_done", busy, 1);
    bus.out_ready = 1'b1;
    clear_count   = clr;
    tick();
    bus.out_ready = 1'b0;
    clear_count   = 1'b0;
    if (clr) exp_cnt = 0;
    else if (exp_err && exp_cnt < CNT_MAX) exp_cnt++;
    check("out_valid_after_hs", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
    check("data_held", bus.out_data, exp_data);
    check("err_count", err_count, exp_cnt);
    txn_cnt++;
    $display("txn %0d code=%03h data=%02h err=%0b syn=%h cnt=%0d",
             txn_cnt, code, bus.out_data, bus.out_error, bus.out_syndrome, err_count);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_error"}, bus.out_error, 0);
    check({tag, "_syndrome"}, bus.out_syndrome, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    logic [CW-1:0] code;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b1;
    tick();
    check_reset_state("post_reset");

    // Spot codewords from the datasheet examples.
    do_txn(12'h013, 1'b0, 0);
    do_txn(12'h80E, 1'b0, 0);
    do_txn(12'h012, 1'b0, 0);
    check("single_flip_count", err_count, 1);
    do_txn(12'h013, 1'b0, 20);
    do_txn(12'h00C, 1'b0, 0);
    do_txn(12'h0F0, 1'b0, 0);
    check("burst_count", err_count, 3);

    // Random mix of clean and corrupted codewords, occasional clears.
    for (int i = 0; i < 30; i++) begin
      code = clean_code(DATA_W'($urandom));
      if ($urandom_range(1, 0) == 1) code = code ^ CW'($urandom_range(CW'((1 << CW) - 1), 1));
      do_txn(code, ($urandom_range(9, 0) == 0), $urandom_range(2, 0));
    end

    // Saturation: every codeword carries a single-bit error.
    for (int i = 0; i < 260; i++) begin
      code = clean_code(DATA_W'($urandom)) ^ (CW'(1) << $urandom_range(CW - 1, 0));
      do_txn(code, 1'b0, 0);
    end
    check("saturated", err_count, CNT_MAX);
    do_txn(12'h012, 1'b1, 0);
    check("clear_wins", err_count, 0);
    do_txn(12'h012, 1'b0, 0);

    // Asynchronous reset in the middle of SHIFT.
    bus.in_valid = 1'b1;
    bus.in_code  = 12'h013;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("busy_mid_shift", busy, 1);
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    check_reset_state("mid_shift_reset");
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("after_mid_reset");
    do_txn(12'h013, 1'b0, 0);
    check("clean_after_reset", bus.out_error, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
